// File: rtl/uart_tx_stream.sv
// uart_tx_stream -- streaming UART transmitter with a valid/ready input.
//
// A word on data_i is accepted on a rising edge where valid_i && ready_o.
// It is then sent as one start bit (0), size_p data bits LSB first,
// an optional even-parity bit and stop_bits_p stop bits (1).
// Each bit lasts clks_per_bit_p clock cycles.
//
// Build option:
//   UART_TX_PARITY_EN  when defined, a PARITY bit (XOR of the data bits)
//                      is sent between DATA and STOP.
//
// Parameters:
//   size_p          data bits per frame (5..9)
//   clks_per_bit_p  clk cycles per serial bit (>= 2)
//   stop_bits_p     stop bits per frame (1 or 2)
//
// Ports:
//   clk      clock, all state on the rising edge
//   rst      asynchronous active-high reset
//   data_i   parallel word to transmit
//   valid_i  data_i holds a word for transmission
//   ready_o  a word can be accepted this cycle (registered)
//   tx_o     serial line, idle high (registered)
//   busy_o   a frame is in progress (registered)

module uart_tx_stream #(
  parameter int size_p         = 8,
  parameter int clks_per_bit_p = 16,
  parameter int stop_bits_p    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [size_p-1:0] data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              tx_o,
  output logic              busy_o
);

  localparam int cnt_w = $clog2(clks_per_bit_p);
  localparam int idx_w = $clog2(size_p + 1);

  localparam logic [cnt_w-1:0] cnt_last  = cnt_w'(clks_per_bit_p - 1);
  localparam logic [idx_w-1:0] idx_last  = idx_w'(size_p - 1);
  localparam logic [idx_w-1:0] stop_last = idx_w'(stop_bits_p - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state;
  logic [cnt_w-1:0]  cnt;    // cycles within the current bit
  logic [idx_w-1:0]  idx;    // data bit index, reused to count stop bits
  logic [size_p-1:0] shift;  // captured word, shifted right as bits go out
`ifdef UART_TX_PARITY_EN
  logic              parity; // even parity of the captured word
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // ready_o is low for the first cycle after reset, so the first
          // edge only raises it; acceptance needs the registered ready_o.
          if (ready_o && valid_i) begin
            shift   <= data_i;
`ifdef UART_TX_PARITY_EN
            parity  <= ^data_i;
`endif
            state   <= START;
            tx_o    <= 1'b0;
            ready_o <= 1'b0;
            busy_o  <= 1'b1;
            cnt     <= '0;
            idx     <= '0;
          end else begin
            ready_o <= 1'b1;
            tx_o    <= 1'b1;
            busy_o  <= 1'b0;
          end
        end

        START: begin
          if (cnt == cnt_last) begin
            cnt   <= '0;
            state <= DATA;
            tx_o  <= shift[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == cnt_last) begin
            cnt <= '0;
            if (idx == idx_last) begin
              idx   <= '0;
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx_o  <= parity;
`else
              state <= STOP;
              tx_o  <= 1'b1;
`endif
            end else begin
              idx   <= idx + 1'b1;
              shift <= shift >> 1;
              // shift[1] is the bit that becomes shift[0] after this edge
              tx_o  <= shift[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cnt == cnt_last) begin
            cnt   <= '0;
            state <= STOP;
            tx_o  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (cnt == cnt_last) begin
            cnt <= '0;
            if (idx == stop_last) begin
              idx     <= '0;
              state   <= IDLE;
              ready_o <= 1'b1;
              busy_o  <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          tx_o    <= 1'b1;
          ready_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// tb_uart_tx_stream -- self-checking bench for uart_tx_stream.
// Expected line levels come from a frame model: start 0, data LSB first,
// optional even parity, then stop 1s, each bit CPB cycles long.

module tb_uart_tx_stream;

  localparam int CPB  = 4;
  localparam int SIZE = 8;
  localparam int STOPB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NBITS = 1 + SIZE + P + STOPB;
  localparam int L     = NBITS * CPB;

  logic            clk;
  logic            rst;
  logic [SIZE-1:0] data_i;
  logic            valid_i;
  logic            ready_o;
  logic            tx_o;
  logic            busy_o;

  int checks = 0;
  int errors = 0;

  uart_tx_stream #(
    .size_p(SIZE),
    .clks_per_bit_p(CPB),
    .stop_bits_p(STOPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_i(data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .tx_o(tx_o),
    .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Level of serial bit b of the frame carrying word w.
  function automatic logic exp_bit(input logic [SIZE-1:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= SIZE) return w[b-1];
    if (P == 1 && b == SIZE + 1) return ^w;
    return 1'b1;
  endfunction

  // Wait (bounded) for ready_o at a negedge, then present w for one edge.
  // Returns at the negedge after the acceptance edge (frame cycle 0).
  task automatic accept(input logic [SIZE-1:0] w, input bit keep_valid, input logic [SIZE-1:0] next_w);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready_o !== 1'b1) check("ready_wait", {31'd0, ready_o}, 32'd1);
    data_i  = w;
    valid_i = 1'b1;
    @(negedge clk);
    if (keep_valid) data_i = next_w;
    else valid_i = 1'b0;
  endtask

  // Check a frame for cycles [0, upto); if upto == L also check the return to IDLE.
  task automatic frame_check(input logic [SIZE-1:0] w, input bit toggle, input bit keep_valid, input int upto);
    for (int c = 0; c < upto; c++) begin
      check($sformatf("tx_w%02h_c%0d", w, c), {31'd0, tx_o}, {31'd0, exp_bit(w, c / CPB)});
      check("ready_in_frame", {31'd0, ready_o}, 32'd0);
      check("busy_in_frame", {31'd0, busy_o}, 32'd1);
      if (toggle) begin
        data_i  = SIZE'($urandom);
        valid_i = (c == L - 1) ? 1'b0 : 1'(($urandom));
      end
      if (c < upto - 1 || upto == L) @(negedge clk);
    end
    if (upto == L) begin
      check("ready_after_frame", {31'd0, ready_o}, 32'd1);
      check("busy_after_frame", {31'd0, busy_o}, 32'd0);
      check("tx_idle_after_frame", {31'd0, tx_o}, 32'd1);
      if (!keep_valid) valid_i = 1'b0;
    end
  endtask

  initial begin
    logic [SIZE-1:0] w;
    rst     = 1'b1;
    data_i  = '0;
    valid_i = 1'b0;
    #23;
    check("rst_tx", {31'd0, tx_o}, 32'd1);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_low_before_edge", {31'd0, ready_o}, 32'd0);
    @(negedge clk);
    check("ready_first_edge", {31'd0, ready_o}, 32'd1);

    // Idle with valid low for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      check("idle_tx", {31'd0, tx_o}, 32'd1);
      check("idle_busy", {31'd0, busy_o}, 32'd0);
      check("idle_ready", {31'd0, ready_o}, 32'd1);
      @(negedge clk);
    end

    // 0xA5 then 0x07 (parity 0 and 1 when enabled).
    accept(8'hA5, 1'b0, '0);
    frame_check(8'hA5, 1'b0, 1'b0, L);
    accept(8'h07, 1'b0, '0);
    frame_check(8'h07, 1'b0, 1'b0, L);

    // Inputs scrambled after acceptance of 0x3C.
    accept(8'h3C, 1'b0, '0);
    frame_check(8'h3C, 1'b1, 1'b0, L);

    // Back-to-back: valid held high with the second word queued.
    accept(8'h96, 1'b1, 8'h4B);
    frame_check(8'h96, 1'b0, 1'b1, L);
    @(negedge clk);
    valid_i = 1'b0;
    check("b2b_accept_busy", {31'd0, busy_o}, 32'd1);
    frame_check(8'h4B, 1'b0, 1'b0, L);

    // Reset during the 3rd data bit.
    accept(8'hF0, 1'b0, '0);
    frame_check(8'hF0, 1'b0, 1'b0, 3 * CPB + 2);
    #2 rst = 1'b1;
    #1;
    check("abort_tx", {31'd0, tx_o}, 32'd1);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_ready", {31'd0, ready_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_abort", {31'd0, ready_o}, 32'd1);
    check("tx_after_abort", {31'd0, tx_o}, 32'd1);
    accept(8'h5A, 1'b0, '0);
    frame_check(8'h5A, 1'b0, 1'b0, L);

    // Random words, some with scrambled inputs during the frame.
    for (int k = 0; k < 8; k++) begin
      w = SIZE'($urandom);
      accept(w, 1'b0, '0);
      frame_check(w, 1'($urandom), 1'b0, L);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_tx_stream.md
UART_TX_STREAM -- requirements
Module: uart_tx_stream

Interface
REQ-001 SHALL have parameter size_p, default 8, meaning data bits per frame (legal 5..9).
REQ-002 SHALL have parameter clks_per_bit_p, default 16, meaning clk cycles per serial bit (legal >= 2).
REQ-003 SHALL have parameter stop_bits_p, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-004 SHALL have port clk, input, 1, meaning clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, meaning reset, asynchronous, active-high.
REQ-006 SHALL have port data_i, input, size_p, meaning parallel word to transmit.
REQ-007 SHALL have port valid_i, input, 1, meaning data_i holds a word for transmission.
REQ-008 SHALL have port ready_o, output, 1, meaning block can accept a word this cycle.
REQ-009 SHALL have port tx_o, output, 1, meaning serial line, idle high.
REQ-010 SHALL have port busy_o, output, 1, meaning a frame is in progress.

Function
REQ-011 SHALL transfer a word only on a rising edge where valid_i && ready_o; no other input combination starts a frame.
REQ-012 SHALL drive ready_o, tx_o and busy_o from registers; none of them SHALL depend combinationally on an input.
REQ-013 SHALL implement the FSM states IDLE, START, DATA, PARITY (present only with PARITY_EN) and STOP.
REQ-014 IDLE: ready_o=1, busy_o=0, tx_o=1.
REQ-015 On the acceptance edge, the block SHALL capture data_i into a shift register, enter START, set tx_o<=0, ready_o<=0 and busy_o<=1.
REQ-016 After the acceptance edge, changes on data_i and valid_i SHALL NOT affect the frame in progress.
REQ-017 START SHALL hold tx_o=0 for exactly clks_per_bit_p cycles.
REQ-018 DATA SHALL send size_p bits LSB first, each for exactly clks_per_bit_p cycles.
REQ-019 STOP SHALL hold tx_o=1 for exactly stop_bits_p*clks_per_bit_p cycles.
REQ-020 At the edge ending STOP, the block SHALL enter IDLE with ready_o<=1 and busy_o<=0.
REQ-021 Frame length from the acceptance edge to the return to IDLE SHALL be (1+size_p+P+stop_bits_p)*clks_per_bit_p cycles, where P=1 with PARITY_EN and P=0 without it.
REQ-022 The minimum gap between acceptance edges SHALL be frame length+1 cycles (one IDLE cycle); for back-to-back frames the line stays high for stop_bits_p*clks_per_bit_p+1 cycles.
REQ-023 The bit-period counter SHALL be $clog2(clks_per_bit_p) bits wide and count from 0 to clks_per_bit_p-1, then wrap to 0 at each bit boundary.
REQ-024 The bit-index counter SHALL be $clog2(size_p+1) bits wide and leave DATA after index size_p-1.
REQ-025 While ready_o=0, valid_i high SHALL be ignored and SHALL NOT be lost state; the upstream holds the word until ready_o=1.

Reset
REQ-026 While rst is high, outputs SHALL be tx_o=1, ready_o=0, busy_o=0, state IDLE, and all counters and the shift register at 0.
REQ-027 Asserting rst mid-frame SHALL abort the frame immediately (asynchronously), with tx_o=1 and no completion.
REQ-028 ready_o SHALL rise at the first rising clk edge after rst deasserts.

Configuration
REQ-029 Macro UART_TX_PARITY_EN defined: the block SHALL insert a PARITY state between DATA and STOP, lasting clks_per_bit_p cycles, with tx_o = XOR of the captured data bits (even parity).
REQ-030 Macro UART_TX_PARITY_EN undefined: the block SHALL go from DATA directly to STOP, and the PARITY state and its logic SHALL be absent.

Verification
REQ-031 Parity off, clks_per_bit_p=4, size_p=8, stop_bits_p=1, accept 0xA5 -> tx_o holds each bit for 4 cycles in the order 0,1,0,1,0,0,1,0,1,1; ready_o returns to 1 after 40 cycles.
REQ-032 UART_TX_PARITY_EN defined, clks_per_bit_p=4, send 0xA5 then 0x07 -> parity bit 0 for 0xA5 and 1 for 0x07; each frame is 44 cycles.
REQ-033 valid_i held high with two queued words -> second acceptance occurs exactly 1 cycle after ready_o rises; line high for 5 cycles between frames at clks_per_bit_p=4.
REQ-034 data_i toggled every cycle after acceptance of 0x3C -> serial bits still encode 0x3C.
REQ-035 rst pulsed during the 3rd data bit -> tx_o=1 immediately; ready_o=1 at the first edge after release; next frame sent intact.
REQ-036 valid_i held low for 100 cycles after reset -> tx_o stays 1, busy_o stays 0 and ready_o stays 1.
